// File: rtl/traffic_pkg.sv
// Shared lamp encodings, ASCII lamp words and the legal-sequence rule for the traffic light monitor.
package traffic_pkg;

    localparam int unsigned LAMP_W = 64;

    typedef enum logic [1:0] {
        CODE_GRN = 2'b00,
        CODE_YEL = 2'b01,
        CODE_RED = 2'b10,
        CODE_INV = 2'b11
    } code_t;

    localparam logic [LAMP_W-1:0] LAMP_GREEN  = "GREEN   ";
    localparam logic [LAMP_W-1:0] LAMP_YELLOW = "YELLOW  ";
    localparam logic [LAMP_W-1:0] LAMP_RED    = "RED     ";

    // Legal steps: GRN->YEL->RED->GRN, and recovery from INV into any valid code.
    function automatic logic is_legal_step(code_t from, code_t to);
        logic ok;
        ok = 1'b0;
        case (from)
            CODE_GRN: ok = (to == CODE_YEL);
            CODE_YEL: ok = (to == CODE_RED);
            CODE_RED: ok = (to == CODE_GRN);
            CODE_INV: ok = (to != CODE_INV);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/light_channel.sv
// One road: lamp decode, code/change/dwell registers and per-edge sequence, yellow and invalid checks.
module light_channel
    import traffic_pkg::*;
#(
    parameter int unsigned YEL_MIN = 4,
    parameter int unsigned DW_W    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [LAMP_W-1:0] lamp,
    output code_t             code,
    output logic              chg,
    output logic [DW_W-1:0]   dwell,
    output logic              seq_c,
    output logic              yel_c,
    output logic              inv_c
);

    localparam logic [DW_W:0] YEL_MIN_W = (DW_W+1)'(YEL_MIN);

    code_t         decoded_c;
    logic          changed_c;
    logic [DW_W:0] dwell_inc_c;

    // Exact full-word match; any other bit pattern is an invalid lamp.
    always_comb begin
        decoded_c = CODE_INV;
        if (lamp == LAMP_GREEN)       decoded_c = CODE_GRN;
        else if (lamp == LAMP_YELLOW) decoded_c = CODE_YEL;
        else if (lamp == LAMP_RED)    decoded_c = CODE_RED;
    end

    assign changed_c   = (decoded_c != code);
    assign dwell_inc_c = {1'b0, dwell} + (DW_W+1)'(1);

    // Violations flagged at the edge that commits the change; extra-wide increment avoids wrap at saturation.
    always_comb begin
        seq_c = 1'b0;
        yel_c = 1'b0;
        inv_c = 1'b0;
        if (changed_c) begin
            if (decoded_c == CODE_INV) begin
                inv_c = 1'b1;
            end else if (code != CODE_INV) begin
                if (!is_legal_step(code, decoded_c)) begin
                    seq_c = 1'b1;
                end else if (code == CODE_YEL && dwell_inc_c < YEL_MIN_W) begin
                    yel_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            code  <= CODE_INV;
            chg   <= 1'b0;
            dwell <= '0;
        end else begin
            code <= decoded_c;
            chg  <= changed_c;
            if (changed_c) begin
                dwell <= '0;
            end else if (!(&dwell)) begin
                dwell <= dwell_inc_c[DW_W-1:0];
            end
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Two-road traffic light monitor: per-road channels plus conflict detection and sticky error flags.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned YEL_MIN = 4,
    parameter int unsigned DW_W    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [LAMP_W-1:0] l_a,
    input  logic [LAMP_W-1:0] l_b,
    input  logic              clr,
    output logic [1:0]        code_a,
    output logic [1:0]        code_b,
    output logic              chg_a,
    output logic              chg_b,
    output logic [DW_W-1:0]   dwell_a,
    output logic [DW_W-1:0]   dwell_b,
    output logic              conflict,
    output logic              err_cfl,
    output logic              err_seq,
    output logic              err_yel,
    output logic              err_inv
);

    code_t code_a_q;
    code_t code_b_q;
    logic  seq_a_c, yel_a_c, inv_a_c;
    logic  seq_b_c, yel_b_c, inv_b_c;

    light_channel #(.YEL_MIN(YEL_MIN), .DW_W(DW_W)) u_chan_a (
        .clk   (clk),
        .rstn  (rstn),
        .lamp  (l_a),
        .code  (code_a_q),
        .chg   (chg_a),
        .dwell (dwell_a),
        .seq_c (seq_a_c),
        .yel_c (yel_a_c),
        .inv_c (inv_a_c)
    );

    light_channel #(.YEL_MIN(YEL_MIN), .DW_W(DW_W)) u_chan_b (
        .clk   (clk),
        .rstn  (rstn),
        .lamp  (l_b),
        .code  (code_b_q),
        .chg   (chg_b),
        .dwell (dwell_b),
        .seq_c (seq_b_c),
        .yel_c (yel_b_c),
        .inv_c (inv_b_c)
    );

    assign code_a = code_a_q;
    assign code_b = code_b_q;

    // GRN and YEL are the only codes with bit 1 clear, so both roads "go" exactly when both MSBs are low.
    assign conflict = ~code_a_q[1] & ~code_b_q[1];

    // Sticky merge: a violation on the same edge as clr keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cfl <= 1'b0;
            err_seq <= 1'b0;
            err_yel <= 1'b0;
            err_inv <= 1'b0;
        end else begin
            err_cfl <= (err_cfl & ~clr) | conflict;
            err_seq <= (err_seq & ~clr) | seq_a_c | seq_b_c;
            err_yel <= (err_yel & ~clr) | yel_a_c | yel_b_c;
            err_inv <= (err_inv & ~clr) | inv_a_c | inv_b_c;
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus randomized traffic against a behavioural model.
module tb_traffic_light_monitor;

    localparam int YEL_MIN = 4;
    localparam int DW_W    = 4;
    localparam int DW_MAX  = (1 << DW_W) - 1;

    localparam logic [63:0] W_GREEN  = "GREEN   ";
    localparam logic [63:0] W_YELLOW = "YELLOW  ";
    localparam logic [63:0] W_RED    = "RED     ";
    localparam logic [63:0] W_BLUE   = "BLUE    ";
    localparam logic [63:0] W_OFF    = "OFF     ";

    logic            clk;
    logic            rstn;
    logic [63:0]     l_a, l_b;
    logic            clr;
    logic [1:0]      code_a, code_b;
    logic            chg_a, chg_b;
    logic [DW_W-1:0] dwell_a, dwell_b;
    logic            conflict, err_cfl, err_seq, err_yel, err_inv;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: lamp index 0=GRN 1=YEL 2=RED 3=INV
    int m_code[2];
    int m_dwell[2];
    bit m_chg[2];
    bit m_cfl, m_seq, m_yel, m_inv;

    traffic_light_monitor #(.YEL_MIN(YEL_MIN), .DW_W(DW_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .l_a      (l_a),
        .l_b      (l_b),
        .clr      (clr),
        .code_a   (code_a),
        .code_b   (code_b),
        .chg_a    (chg_a),
        .chg_b    (chg_b),
        .dwell_a  (dwell_a),
        .dwell_b  (dwell_b),
        .conflict (conflict),
        .err_cfl  (err_cfl),
        .err_seq  (err_seq),
        .err_yel  (err_yel),
        .err_inv  (err_inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int word_code(input logic [63:0] w);
        if (w == W_GREEN)  return 0;
        if (w == W_YELLOW) return 1;
        if (w == W_RED)    return 2;
        return 3;
    endfunction

    function automatic logic [18:0] snap();
        return {code_a, code_b, chg_a, chg_b, dwell_a, dwell_b, conflict,
                err_cfl, err_seq, err_yel, err_inv};
    endfunction

    function automatic logic [18:0] model_vec();
        bit go;
        go = (m_code[0] < 2) && (m_code[1] < 2);
        return {2'(m_code[0]), 2'(m_code[1]), m_chg[0], m_chg[1],
                4'(m_dwell[0]), 4'(m_dwell[1]), go, m_cfl, m_seq, m_yel, m_inv};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            m_code[r] = 3; m_dwell[r] = 0; m_chg[r] = 0;
        end
        m_cfl = 0; m_seq = 0; m_yel = 0; m_inv = 0;
    endtask

    // Drive one cycle of inputs, advance the model by the road rules, sample 1 time unit after the edge.
    task automatic step(input logic [63:0] a, input logic [63:0] b, input bit c);
        bit go, s, y, v;
        int d;
        l_a = a; l_b = b; clr = c;
        go = (m_code[0] < 2) && (m_code[1] < 2);
        s = 0; y = 0; v = 0;
        for (int r = 0; r < 2; r++) begin
            d = word_code(r == 0 ? a : b);
            if (d != m_code[r]) begin
                if (d == 3) v = 1;
                else if (m_code[r] != 3) begin
                    if (d != (m_code[r] + 1) % 3) s = 1;
                    else if (m_code[r] == 1 && m_dwell[r] + 1 < YEL_MIN) y = 1;
                end
                m_code[r] = d; m_dwell[r] = 0; m_chg[r] = 1;
            end else begin
                m_chg[r] = 0;
                if (m_dwell[r] < DW_MAX) m_dwell[r]++;
            end
        end
        m_cfl = (m_cfl && !c) || go;
        m_seq = (m_seq && !c) || s;
        m_yel = (m_yel && !c) || y;
        m_inv = (m_inv && !c) || v;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; clr = 1'b0; l_a = W_OFF; l_b = W_OFF;
        @(posedge clk); #1;
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rstn = 1'b0; clr = 1'b0; l_a = W_GREEN; l_b = W_YELLOW;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (snap() !== {4'b1111, 15'b0}) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got %h required %h", i, snap(), {4'b1111, 15'b0});
            end
        end
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_first_red();
        do_reset();
        step(W_RED, W_OFF, 0);
        n_cmp++;
        if ({code_a, chg_a} !== 3'b10_1) begin
            n_bad++; $display("FAIL first_red code/chg: got %b required 101", {code_a, chg_a});
        end
        n_cmp++;
        if ({err_cfl, err_seq, err_yel, err_inv} !== 4'b0) begin
            n_bad++; $display("FAIL first_red errs: got %b required 0000", {err_cfl, err_seq, err_yel, err_inv});
        end
    endtask

    task automatic test_normal_cycle();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(W_GREEN, W_OFF, 0);
            pulses += int'(chg_a);
        end
        n_cmp++;
        if (dwell_a !== 4'd9) begin
            n_bad++; $display("FAIL normal_dwell_green: got %0d required 9", dwell_a);
        end
        for (int i = 0; i < 4; i++) begin
            step(W_YELLOW, W_OFF, 0);
            pulses += int'(chg_a);
        end
        step(W_RED, W_OFF, 0);
        pulses += int'(chg_a);
        n_cmp++;
        if (pulses != 3 || code_a !== 2'b10) begin
            n_bad++; $display("FAIL normal_pulses: got %0d pulses code %b required 3 pulses code 10", pulses, code_a);
        end
        n_cmp++;
        if ({err_cfl, err_seq, err_yel, err_inv} !== 4'b0) begin
            n_bad++; $display("FAIL normal_errs: got %b required 0000", {err_cfl, err_seq, err_yel, err_inv});
        end
    endtask

    task automatic test_short_yellow(input int len);
        do_reset();
        step(W_GREEN, W_OFF, 0);
        step(W_GREEN, W_OFF, 0);
        for (int i = 0; i < len; i++) step(W_YELLOW, W_OFF, 0);
        step(W_RED, W_OFF, 0);
        n_cmp++;
        if ({err_yel, err_seq} !== 2'b10) begin
            n_bad++; $display("FAIL short_yellow_%0d yel/seq: got %b required 10", len, {err_yel, err_seq});
        end
    endtask

    task automatic test_skip_and_clear();
        do_reset();
        step(W_GREEN, W_OFF, 0);
        step(W_GREEN, W_OFF, 0);
        step(W_RED, W_OFF, 0);
        n_cmp++;
        if ({err_seq, err_yel} !== 2'b10) begin
            n_bad++; $display("FAIL skip_seq: got %b required 10", {err_seq, err_yel});
        end
        step(W_RED, W_OFF, 1);
        n_cmp++;
        if (err_seq !== 1'b0) begin
            n_bad++; $display("FAIL clear_seq: got %b required 0", err_seq);
        end
        step(W_YELLOW, W_OFF, 1);
        n_cmp++;
        if (err_seq !== 1'b1) begin
            n_bad++; $display("FAIL clr_vs_violation: got %b required 1", err_seq);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        step(W_GREEN, W_YELLOW, 0);
        n_cmp++;
        if ({conflict, err_cfl} !== 2'b10) begin
            n_bad++; $display("FAIL conflict_now: got %b required 10", {conflict, err_cfl});
        end
        step(W_GREEN, W_YELLOW, 0);
        n_cmp++;
        if (err_cfl !== 1'b1) begin
            n_bad++; $display("FAIL conflict_sticky: got %b required 1", err_cfl);
        end
        step(W_GREEN, W_YELLOW, 1);
        n_cmp++;
        if (err_cfl !== 1'b1) begin
            n_bad++; $display("FAIL conflict_vs_clr: got %b required 1", err_cfl);
        end
        step(W_GREEN, W_RED, 0);
        step(W_GREEN, W_RED, 1);
        n_cmp++;
        if ({conflict, err_cfl} !== 2'b00) begin
            n_bad++; $display("FAIL conflict_cleared: got %b required 00", {conflict, err_cfl});
        end
    endtask

    task automatic test_both_roads();
        do_reset();
        step(W_GREEN, W_RED, 0);
        step(W_RED, W_BLUE, 0);
        n_cmp++;
        if ({err_seq, err_inv, code_b} !== 4'b1111) begin
            n_bad++; $display("FAIL both_roads seq/inv/code_b: got %b required 1111", {err_seq, err_inv, code_b});
        end
    endtask

    task automatic test_invalid_and_reset();
        do_reset();
        step(W_OFF, W_RED, 0);
        step(W_OFF, W_BLUE, 0);
        n_cmp++;
        if ({code_b, chg_b, err_inv} !== 4'b1111) begin
            n_bad++; $display("FAIL blue_lamp code/chg/inv: got %b required 1111", {code_b, chg_b, err_inv});
        end
        for (int i = 0; i < 3; i++) step(W_GREEN, W_BLUE, 0);
        #3 rstn = 1'b0;
        #1;
        n_cmp++;
        if (snap() !== {4'b1111, 15'b0}) begin
            n_bad++; $display("FAIL async_reset: got %h required %h", snap(), {4'b1111, 15'b0});
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        model_reset();
        step(W_YELLOW, W_OFF, 0);
        n_cmp++;
        if ({code_a, chg_a, err_seq, err_yel, err_inv} !== 6'b01_1_000) begin
            n_bad++; $display("FAIL post_reset_first: got %b required 011000", {code_a, chg_a, err_seq, err_yel, err_inv});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) step(W_RED, W_OFF, 0);
        n_cmp++;
        if (dwell_a !== 4'hF) begin
            n_bad++; $display("FAIL dwell_saturate: got %0d required 15", dwell_a);
        end
        step(W_GREEN, W_OFF, 0);
        for (int i = 0; i < 20; i++) step(W_YELLOW, W_OFF, 0);
        step(W_RED, W_OFF, 0);
        n_cmp++;
        if ({err_yel, err_seq, dwell_a} !== 6'b0) begin
            n_bad++; $display("FAIL long_yellow: got %b required 000000", {err_yel, err_seq, dwell_a});
        end
    endtask

    task automatic test_random();
        logic [63:0] words[3];
        logic [63:0] cur[2];
        logic [63:0] nxt;
        int idx, r;
        words[0] = W_GREEN; words[1] = W_YELLOW; words[2] = W_RED;
        do_reset();
        cur[0] = W_OFF; cur[1] = W_OFF;
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 2; k++) begin
                r = int'($urandom_range(0, 15));
                idx = word_code(cur[k]);
                if (r < 10) nxt = cur[k];
                else if (r < 13) nxt = (idx == 3) ? words[$urandom_range(0, 2)] : words[(idx + 1) % 3];
                else if (r < 15) nxt = words[$urandom_range(0, 2)];
                else nxt = words[$urandom_range(0, 2)] ^ (64'h1 << $urandom_range(0, 63));
                cur[k] = nxt;
            end
            step(cur[0], cur[1], $urandom_range(0, 15) == 0);
            n_cmp++;
            if (snap() !== model_vec()) begin
                n_bad++;
                $display("FAIL random[%0d]: got %h required %h", i, snap(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_red();
        test_normal_cycle();
        test_short_yellow(2);
        test_short_yellow(3);
        test_skip_and_clear();
        test_conflict();
        test_both_roads();
        test_invalid_and_reset();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter YEL_MIN, default 4: minimum legal YELLOW dwell, in cycles.
REQ-002 Parameter DW_W, default 16: dwell counter width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 l_a  input  64  road-A lamp, 8-char ASCII, MSB byte first.
REQ-006 l_b  input  64  road-B lamp, same format as l_a.
REQ-007 clr  input  1  synchronous clear of sticky flags.
REQ-008 code_a, code_b  output  2 each  decoded lamp: GRN=00, YEL=01, RED=10, INV=11.
REQ-009 chg_a, chg_b  output  1 each  one-cycle pulse on a code change.
REQ-010 dwell_a, dwell_b  output  DW_W each  edges since last code change, saturating.
REQ-011 conflict  output  1  both roads non-RED and valid this cycle.
REQ-012 err_cfl, err_seq, err_yel, err_inv  output  1 each  sticky violation flags.

Function
REQ-013 Decode SHALL be exact 64-bit match: "GREEN   "->GRN, "YELLOW  "->YEL, "RED     "->RED, anything else->INV.
REQ-014 Latency SHALL be 1: l_x sampled at edge N appears on code_x after edge N.
REQ-015 At each edge, chg_x <= (decoded != code_x).
REQ-016 At each edge, dwell_x <= 0 if decoded != code_x, else dwell_x+1, saturating at all-ones.
REQ-017 Legal transitions: GRN->YEL, YEL->RED, RED->GRN, and INV->any valid code.
REQ-018 Any other change between valid codes SHALL set err_seq at that edge.
REQ-019 Any change into INV SHALL set err_inv.
REQ-020 On a YEL->RED change with dwell_x+1 < YEL_MIN, err_yel SHALL be set.
REQ-021 conflict SHALL be combinational from code_a and code_b: both in {GRN, YEL}.
REQ-022 err_cfl SHALL be set at the edge after conflict is high.
REQ-023 Sticky flags SHALL hold until clr or reset; clr clears them at the next edge.
REQ-024 A violation coincident with clr SHALL win: the flag remains set.
REQ-025 Roads A and B SHALL be checked independently; violations on both roads in the same cycle SHALL set all applicable flags.

Reset
REQ-026 While rstn=0: code_a=code_b=INV, chg=0, dwell=0, conflict=0, all err flags=0.
REQ-027 Reset asserted mid-operation SHALL take effect immediately and discard all history.
REQ-028 The first valid code after reset is an INV->valid transition: legal, and not a yellow check.

Structure
REQ-029 Shared package traffic_pkg SHALL hold the code encodings and the three 64-bit ASCII constants.
REQ-030 Sub-module light_channel SHALL hold decode, code register, chg, dwell, and the seq/yel/inv checks; it is instantiated once per road.
REQ-031 The top level SHALL hold only the conflict logic and the sticky-flag merge.

Verification
REQ-032 Scenario 1: reset, then l_a="RED     " -> code_a=10 and chg_a=1 one edge later; no err flags.
REQ-033 Scenario 2: l_a GREEN 10cy, YELLOW 4cy, RED -> chg_a pulses 3 times, dwell_a=9 at the last GREEN edge, no errors.
REQ-034 Scenario 3: l_a GREEN->YELLOW for 2cy->RED -> err_yel=1 at the RED edge; err_seq stays 0.
REQ-035 Scenario 4: l_a GREEN->RED directly -> err_seq=1; then clr=1 for 1cy -> err_seq=0.
REQ-036 Scenario 5: l_a="GREEN   ", l_b="YELLOW  " together -> conflict=1 immediately, err_cfl=1 next edge.
REQ-037 Scenario 6: l_b="BLUE    " -> code_b=11, err_inv=1; rstn pulsed low mid-sequence -> all outputs return to REQ-026 values asynchronously.
